// File: rtl/rfifo_rd_sched.sv
// Read-response scheduler: queues read-burst descriptors and tags FIFO words
// with RID/RLAST on the AXI4 R channel.
// Optional feature macro: RFIFO_LAST_CHECK_EN (compare fifo_rd_last against
// the counter-derived RLAST and flag mismatches with SLVERR + err_sticky).
module rfifo_rd_sched #(
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned CMD_DEPTH      = 4
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ID_WIDTH-1:0]       cmd_id,
  input  logic [7:0]                cmd_len,
  input  logic [DATA_BUS_WIDTH-1:0] fifo_rd_dout,
  input  logic                      fifo_rd_last,
  input  logic                      fifo_rd_empty,
  output logic                      fifo_rd_en,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_BUS_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      busy,
  output logic                      err_sticky
);

  localparam int unsigned LEN_W = 8;
  localparam int unsigned ENT_W = ID_WIDTH + LEN_W;
  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e              state_q, state_d;
  logic [ENT_W-1:0]    cmd_mem_q [CMD_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ID_WIDTH-1:0] cur_id_q, cur_id_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic                push, pop, q_empty, in_burst;
  logic                rvalid_c, rlast_c, hs_c;
  logic [ENT_W-1:0]    head_c;
  logic [ID_WIDTH-1:0] head_id_c;
  logic [LEN_W-1:0]    head_len_c;

  assign q_empty    = (count_q == '0);
  assign push       = cmd_valid & cmd_ready_q;
  assign in_burst   = (state_q == ST_BURST);
  assign rvalid_c   = in_burst & ~fifo_rd_empty;
  assign rlast_c    = in_burst & (beat_cnt_q == '0);
  assign hs_c       = rvalid_c & s_axi_rready;
  assign head_c     = cmd_mem_q[rd_ptr_q];
  assign head_id_c  = head_c[LEN_W +: ID_WIDTH];
  assign head_len_c = head_c[LEN_W-1:0];

  // Descriptor storage; validity is tracked by count_q, so no reset needed.
  always_ff @(posedge s_axi_aclk) begin
    if (push) cmd_mem_q[wr_ptr_q] <= {cmd_id, cmd_len};
  end

  // Burst FSM: load a descriptor, count beats, chain bursts without a bubble.
  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    beat_cnt_d = beat_cnt_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          pop        = 1'b1;
          cur_id_d   = head_id_c;
          beat_cnt_d = head_len_c;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (hs_c) begin
          if (!rlast_c) begin
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
          end else if (!q_empty) begin
            pop        = 1'b1;
            cur_id_d   = head_id_c;
            beat_cnt_d = head_len_c;
          end else begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue pointers and occupancy; ready reflects the post-update count so a
  // full queue refuses a push even while it pops.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    cmd_ready_d = (count_d != CNT_W'(CMD_DEPTH));
  end

  // State registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      cur_id_q    <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      cur_id_q    <= cur_id_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

`ifdef RFIFO_LAST_CHECK_EN
  logic err_sticky_q, err_sticky_d, mismatch_c;

  assign mismatch_c = rvalid_c & (fifo_rd_last != rlast_c);

  // Sticky mismatch flag, set on a handshaked beat whose FIFO last disagrees.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (hs_c && mismatch_c) err_sticky_d = 1'b1;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) err_sticky_q <= 1'b0;
    else                err_sticky_q <= err_sticky_d;
  end

  assign s_axi_rresp = mismatch_c ? 2'b10 : 2'b00;
  assign err_sticky  = err_sticky_q;
`else
  logic unused_last;
  assign unused_last = fifo_rd_last;
  assign s_axi_rresp = 2'b00;
  assign err_sticky  = 1'b0;
`endif

  assign cmd_ready    = cmd_ready_q;
  assign fifo_rd_en   = hs_c;
  assign s_axi_rid    = cur_id_q;
  assign s_axi_rdata  = in_burst ? fifo_rd_dout : '0;
  assign s_axi_rlast  = rlast_c;
  assign s_axi_rvalid = rvalid_c;
  assign busy         = in_burst | ~q_empty;

endmodule

// File: tb/tb_rfifo_rd_sched.sv
// Directed testbench for rfifo_rd_sched with a queue-based FWFT FIFO model.
module tb_rfifo_rd_sched;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
`ifdef RFIFO_LAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready;
  logic [IW-1:0] cmd_id;
  logic [7:0]    cmd_len;
  logic [DW-1:0] fifo_rd_dout;
  logic          fifo_rd_last, fifo_rd_empty, fifo_rd_en;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic          busy, err_sticky;

  int checks = 0;
  int passes = 0;
  int edge_n = 0;

  logic [DW-1:0] fq_data[$];
  logic          fq_last[$];
  logic [IW-1:0] b_id[$];
  logic [DW-1:0] b_data[$];
  logic          b_last[$];
  logic [1:0]    b_resp[$];
  int            b_edge[$];

  rfifo_rd_sched #(.DATA_BUS_WIDTH(DW), .ID_WIDTH(IW), .CMD_DEPTH(4)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_id       (cmd_id),
    .cmd_len      (cmd_len),
    .fifo_rd_dout (fifo_rd_dout),
    .fifo_rd_last (fifo_rd_last),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en   (fifo_rd_en),
    .s_axi_rid    (s_axi_rid),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rlast  (s_axi_rlast),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .busy         (busy),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passes, checks);
    $fatal(1, "time limit");
  end

  task automatic drive_fifo();
    fifo_rd_empty = (fq_data.size() == 0);
    if (fq_data.size() != 0) begin
      fifo_rd_dout = fq_data[0];
      fifo_rd_last = fq_last[0];
    end else begin
      fifo_rd_dout = '0;
      fifo_rd_last = 1'b0;
    end
  endtask

  task automatic add_word(input logic [DW-1:0] d, input logic l);
    fq_data.push_back(d);
    fq_last.push_back(l);
    drive_fifo();
  endtask

  task automatic clear_beats();
    b_id.delete(); b_data.delete(); b_last.delete(); b_resp.delete(); b_edge.delete();
  endtask

  // Called near a negedge: record any handshake, cross the next posedge, pop the model.
  task automatic adv();
    logic pop;
    pop = fifo_rd_en;
    if (s_axi_rvalid && s_axi_rready) begin
      b_id.push_back(s_axi_rid);
      b_data.push_back(s_axi_rdata);
      b_last.push_back(s_axi_rlast);
      b_resp.push_back(s_axi_rresp);
      b_edge.push_back(edge_n + 1);
    end
    @(posedge clk);
    #1;
    edge_n++;
    if (pop && fq_data.size() != 0) begin
      fq_data.delete(0);
      fq_last.delete(0);
    end
    drive_fifo();
  endtask

  task automatic push_cmd(input logic [IW-1:0] id, input logic [7:0] len, input int budget,
                          output bit acc, output int acc_edge);
    cmd_id = id; cmd_len = len; cmd_valid = 1'b1; acc = 1'b0; acc_edge = -1;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = 1'b1;
        acc_edge = edge_n + 1;
      end
      adv();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && b_id.size() < n; i++) begin
      @(negedge clk);
      adv();
    end
  endtask

  task automatic test_reset();
    add_word(32'hDEAD_BEEF, 1'b1);
    cmd_valid = 1'b0; s_axi_rready = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, fifo_rd_en, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
         s_axi_rvalid, busy, err_sticky} !== '0)
      $display("FAIL reset_outputs: got rdy=%b en=%b rid=%h rdata=%h rresp=%b rlast=%b rvalid=%b busy=%b err=%b want all 0",
               cmd_ready, fifo_rd_en, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
               s_axi_rvalid, busy, err_sticky);
    else passes++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) $display("FAIL reset_ready_before_clk: got %b want 0", cmd_ready);
    else passes++;
    adv();
    checks++;
    if ({cmd_ready, busy} !== 2'b10) $display("FAIL reset_ready_after_clk: got rdy,busy=%b want 10", {cmd_ready, busy});
    else passes++;
    fq_data.delete(); fq_last.delete(); drive_fifo();
  endtask

  task automatic test_single();
    bit acc; int e;
    logic [DW-1:0] w[4];
    w[0] = 32'hA5A5_000A; w[1] = 32'hA5A5_000B; w[2] = 32'hA5A5_000C; w[3] = 32'hA5A5_000D;
    clear_beats(); s_axi_rready = 1'b1;
    for (int i = 0; i < 4; i++) add_word(w[i], i == 3);
    push_cmd(4'd3, 8'd3, 5, acc, e);
    @(negedge clk);
    checks++;
    if ({acc, busy} !== 2'b11) $display("FAIL single_accept_busy: got acc,busy=%b want 11", {acc, busy});
    else passes++;
    adv();
    wait_beats(4, 20);
    checks++;
    if (b_id.size() != 4) $display("FAIL single_beat_count: got %0d want 4", b_id.size());
    else begin
      passes++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({b_id[i], b_data[i], b_last[i], b_resp[i]} !== {4'd3, w[i], (i == 3), 2'b00})
          $display("FAIL single_beat%0d: got id=%h data=%h last=%b resp=%b want id=3 data=%h last=%b resp=00",
                   i, b_id[i], b_data[i], b_last[i], b_resp[i], w[i], (i == 3));
        else passes++;
      end
      checks++;
      if (b_edge[0] != e + 2) $display("FAIL single_latency: got edge %0d want %0d", b_edge[0], e + 2);
      else passes++;
      checks++;
      if (b_edge[3] != b_edge[0] + 3) $display("FAIL single_contiguous: got span %0d want 3", b_edge[3] - b_edge[0]);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy);
    else passes++;
    adv();
  endtask

  task automatic test_back_to_back();
    bit acc; int e;
    logic [DW-1:0] w[3];
    logic [IW-1:0] id[3];
    logic          l[3];
    w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h2222_0003;
    id[0] = 4'd1; id[1] = 4'd2; id[2] = 4'd2;
    l[0] = 1'b1; l[1] = 1'b0; l[2] = 1'b1;
    clear_beats(); s_axi_rready = 1'b0;
    for (int i = 0; i < 3; i++) add_word(w[i], l[i]);
    push_cmd(4'd1, 8'd0, 5, acc, e);
    push_cmd(4'd2, 8'd1, 5, acc, e);
    s_axi_rready = 1'b1;
    wait_beats(3, 20);
    checks++;
    if (b_id.size() != 3) $display("FAIL b2b_beat_count: got %0d want 3", b_id.size());
    else begin
      passes++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({b_id[i], b_data[i], b_last[i]} !== {id[i], w[i], l[i]})
          $display("FAIL b2b_beat%0d: got id=%h data=%h last=%b want id=%h data=%h last=%b",
                   i, b_id[i], b_data[i], b_last[i], id[i], w[i], l[i]);
        else passes++;
      end
      checks++;
      if (b_edge[1] != b_edge[0] + 1) $display("FAIL b2b_no_bubble_1: got gap %0d want 1", b_edge[1] - b_edge[0]);
      else passes++;
      checks++;
      if (b_edge[2] != b_edge[1] + 1) $display("FAIL b2b_no_bubble_2: got gap %0d want 1", b_edge[2] - b_edge[1]);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL b2b_busy_after: got %b want 0", busy);
    else passes++;
    adv();
  endtask

  task automatic test_full();
    bit acc; int e; int n_acc;
    clear_beats(); s_axi_rready = 1'b1; n_acc = 0;
    // First descriptor leaves the queue into the stalled burst, so five fit.
    for (int i = 0; i < 5; i++) begin
      push_cmd(IW'(i + 1), 8'd0, 3, acc, e);
      if (acc) n_acc++;
    end
    checks++;
    if (n_acc != 5) $display("FAIL full_accepted: got %0d want 5", n_acc);
    else passes++;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b01) $display("FAIL full_ready_low: got rdy,busy=%b want 01", {cmd_ready, busy});
    else passes++;
    adv();
    cmd_id = 4'd6; cmd_len = 8'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) $display("FAIL full_refuse%0d: got ready %b want 0", i, cmd_ready);
      else passes++;
      adv();
    end
    add_word(32'h6000_0001, 1'b1);
    push_cmd(4'd6, 8'd0, 10, acc, e);
    checks++;
    if (!(acc && b_edge.size() == 1 && e == b_edge[0] + 1))
      $display("FAIL full_accept_after_burst: got acc=%b beats=%0d accept_edge=%0d want accept one edge after first beat",
               acc, b_edge.size(), e);
    else passes++;
    for (int i = 2; i <= 6; i++) add_word(DW'(32'h6000_0000 + i), 1'b1);
    wait_beats(6, 30);
    checks++;
    if (b_id.size() != 6) $display("FAIL full_beat_count: got %0d want 6", b_id.size());
    else begin
      passes++;
      for (int i = 0; i < 6; i++) begin
        checks++;
        if ({b_id[i], b_data[i], b_last[i]} !== {IW'(i + 1), DW'(32'h6000_0001 + i), 1'b1})
          $display("FAIL full_order%0d: got id=%h data=%h last=%b want id=%0d data=%h last=1",
                   i, b_id[i], b_data[i], b_last[i], i + 1, 32'h6000_0001 + i);
        else passes++;
      end
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b10) $display("FAIL full_drained: got rdy,busy=%b want 10", {cmd_ready, busy});
    else passes++;
    adv();
  endtask

  task automatic test_underrun();
    bit acc; int e; int gap_left; bit gap_done, refilled, prev_stall;
    logic [DW-1:0] prev_data; logic [IW-1:0] prev_id; logic prev_last;
    logic [15:0] pat;
    int k;
    pat = 16'b1101_1011_0110_1010;
    clear_beats(); s_axi_rready = 1'b0;
    gap_left = 0; gap_done = 1'b0; refilled = 1'b0; prev_stall = 1'b0; k = 0;
    prev_data = '0; prev_id = '0; prev_last = 1'b0;
    for (int i = 0; i < 3; i++) add_word(DW'(32'h9000_0000 + i), 1'b0);
    push_cmd(4'd9, 8'd7, 5, acc, e);
    for (int c = 0; c < 200 && b_id.size() < 8; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if ({s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rlast} !== {1'b1, prev_data, prev_id, prev_last})
          $display("FAIL underrun_stall_stable: got v=%b d=%h id=%h l=%b want v=1 d=%h id=%h l=%b",
                   s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rlast, prev_data, prev_id, prev_last);
        else passes++;
      end
      if (gap_left > 0) begin
        checks++;
        if (s_axi_rvalid !== 1'b0) $display("FAIL underrun_gap_rvalid: got %b want 0", s_axi_rvalid);
        else passes++;
        gap_left--;
      end
      prev_stall = s_axi_rvalid && !s_axi_rready;
      prev_data = s_axi_rdata; prev_id = s_axi_rid; prev_last = s_axi_rlast;
      adv();
      if (!gap_done && b_id.size() == 3) begin
        gap_done = 1'b1;
        gap_left = 5;
      end else if (gap_done && gap_left == 0 && !refilled) begin
        for (int i = 3; i < 8; i++) add_word(DW'(32'h9000_0000 + i), i == 7);
        refilled = 1'b1;
      end
      s_axi_rready = pat[k % 16];
      k++;
    end
    checks++;
    if (b_id.size() != 8) $display("FAIL underrun_beat_count: got %0d want 8", b_id.size());
    else begin
      passes++;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if ({b_id[i], b_data[i], b_last[i]} !== {4'd9, DW'(32'h9000_0000 + i), (i == 7)})
          $display("FAIL underrun_beat%0d: got id=%h data=%h last=%b want id=9 data=%h last=%b",
                   i, b_id[i], b_data[i], b_last[i], 32'h9000_0000 + i, (i == 7));
        else passes++;
      end
    end
    s_axi_rready = 1'b1;
    wait_beats(9, 3);
  endtask

  task automatic test_last_check();
    bit acc; int e;
    logic [1:0] exp_resp;
    clear_beats(); s_axi_rready = 1'b1;
    @(negedge clk);
    checks++;
    if (err_sticky !== 1'b0) $display("FAIL lastchk_err_before: got %b want 0", err_sticky);
    else passes++;
    adv();
    add_word(32'h5000_0001, 1'b0);
    add_word(32'h5000_0002, 1'b1);
    add_word(32'h5000_0003, 1'b0);
    add_word(32'h5000_0004, 1'b1);
    push_cmd(4'd5, 8'd3, 5, acc, e);
    for (int c = 0; c < 20 && b_id.size() < 4; c++) begin
      @(negedge clk);
      if (b_id.size() == 1) begin
        checks++;
        if (err_sticky !== 1'b0) $display("FAIL lastchk_err_early: got %b want 0", err_sticky);
        else passes++;
      end
      if (b_id.size() >= 2) begin
        checks++;
        if (err_sticky !== CHK) $display("FAIL lastchk_err_set: got %b want %b", err_sticky, CHK);
        else passes++;
      end
      adv();
    end
    checks++;
    if (b_id.size() != 4) $display("FAIL lastchk_beat_count: got %0d want 4", b_id.size());
    else begin
      passes++;
      for (int i = 0; i < 4; i++) begin
        exp_resp = (i == 1 && CHK) ? 2'b10 : 2'b00;
        checks++;
        if ({b_id[i], b_data[i], b_last[i], b_resp[i]} !== {4'd5, DW'(32'h5000_0001 + i), (i == 3), exp_resp})
          $display("FAIL lastchk_beat%0d: got id=%h data=%h last=%b resp=%b want id=5 data=%h last=%b resp=%b",
                   i, b_id[i], b_data[i], b_last[i], b_resp[i], 32'h5000_0001 + i, (i == 3), exp_resp);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit acc; int e;
    clear_beats(); s_axi_rready = 1'b1;
    for (int i = 0; i < 4; i++) add_word(DW'(32'h6600_0000 + i), i == 3);
    push_cmd(4'd6, 8'd3, 5, acc, e);
    wait_beats(1, 10);
    @(negedge clk);
    checks++;
    if ({s_axi_rvalid, err_sticky, s_axi_rdata} !== {1'b1, CHK, 32'h6600_0001})
      $display("FAIL midrst_before: got v=%b err=%b d=%h want v=1 err=%b d=66000001",
               s_axi_rvalid, err_sticky, s_axi_rdata, CHK);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, fifo_rd_en, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
         s_axi_rvalid, busy, err_sticky} !== '0)
      $display("FAIL midrst_outputs: got rdy=%b en=%b rid=%h rdata=%h rresp=%b rlast=%b rvalid=%b busy=%b err=%b want all 0",
               cmd_ready, fifo_rd_en, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
               s_axi_rvalid, busy, err_sticky);
    else passes++;
    fq_data.delete(); fq_last.delete(); drive_fifo();
    clear_beats();
    adv();
    @(negedge clk);
    rst_n = 1'b1;
    adv();
    add_word(32'hC0DE_0001, 1'b0);
    add_word(32'hC0DE_0002, 1'b1);
    push_cmd(4'd12, 8'd1, 5, acc, e);
    wait_beats(2, 20);
    checks++;
    if (b_id.size() != 2) $display("FAIL midrst_beat_count: got %0d want 2", b_id.size());
    else begin
      passes++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({b_id[i], b_data[i], b_last[i], b_resp[i]} !== {4'd12, DW'(32'hC0DE_0001 + i), (i == 1), 2'b00})
          $display("FAIL midrst_beat%0d: got id=%h data=%h last=%b resp=%b want id=c data=%h last=%b resp=00",
                   i, b_id[i], b_data[i], b_last[i], b_resp[i], 32'hC0DE_0001 + i, (i == 1));
        else passes++;
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, err_sticky} !== 2'b00) $display("FAIL midrst_after: got busy,err=%b want 00", {busy, err_sticky});
    else passes++;
    adv();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0; s_axi_rready = 1'b0;
    drive_fifo();
    #2 rst_n = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_underrun();
    test_last_check();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
